// File: rtl/dm_pkg.sv
// Shared defaults and FSM state encoding for the two-requester data-memory arbiter.
package dm_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester that was not last served.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_id,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_id;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares one single-cycle data memory between two requesters; each access takes
// IDLE -> ACCESS -> RESP, so one access completes every three cycles.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData,
  output logic              busy
);

  state_e state_q, state_d;

  logic              last_id_q;
  logic              id_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              winner;
  logic              any_req;
  logic              grant;

  assign any_req = req0 | req1;
  assign grant   = (state_q == IDLE) & any_req;

  rr_arb2 u_rr_arb2 (
    .req     ({req1, req0}),
    .last_id (last_id_q),
    .winner  (winner)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      ACCESS: begin
        gnt0     = ~id_q;
        gnt1     = id_q;
        MemRead  = ~we_q;
        // Gated by reset so a write in flight can never reach the memory edge.
        MemWrite = we_q & ~reset;
        busy     = 1'b1;
      end
      RESP: begin
        done0 = ~id_q;
        done1 = id_q;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // Command latch; last_id starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_id_q <= 1'b1;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (grant) begin
      last_id_q <= winner;
      id_q      <= winner;
      we_q      <= winner ? we1 : we0;
      addr_q    <= winner ? addr1 : addr0;
      wdata_q   <= winner ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if ((state_q == ACCESS) && !we_q) begin
      if (id_q) begin
        rdata1_q <= ReadData;
      end else begin
        rdata0_q <= ReadData;
      end
    end
  end

  assign Address   = addr_q;
  assign WriteData = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic, all checked against a
// transaction-level model that tracks grant edge, winner and a reference memory.
module tb_dm_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1, MemRead, MemWrite, busy;
  logic [DW-1:0] rdata0, rdata1, WriteData, ReadData;
  logic [AW-1:0] Address;

  logic [DW-1:0] mem [256] = '{default: '0};
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  int            wr_cnt = 0;

  int checks = 0;
  int failures = 0;

  // Model: a transaction granted at edge k is in ACCESS after edge k, RESP after edge k+1,
  // and the arbiter may grant again at edge k+3.
  int            e = 0;
  int            k = 0;
  bit            act = 1'b0;
  bit            m_id = 1'b0;
  bit            m_last = 1'b1;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata [2] = '{default: '0};
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  int            m_wr_cnt = 0;

  always #5 clock = ~clock;

  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .busy      (busy)
  );

  always @(posedge clock) begin
    if (MemWrite) begin
      mem[Address] <= WriteData;
      wr_cnt       <= wr_cnt + 1;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  assign ReadData = mem[Address];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    act        = 1'b0;
    m_id       = 1'b0;
    m_last     = 1'b1;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  task automatic model_edge();
    e++;
    if (act && e == k + 1) begin
      if (m_we) begin
        ref_mem[m_addr] = m_wdata;
        m_wr_cnt++;
      end else begin
        m_rdata[m_id] = ref_mem[m_addr];
      end
    end
    if (act && e >= k + 3) act = 1'b0;
    if (!act && (req0 || req1)) begin
      m_id    = (req0 && req1) ? !m_last : req1;
      m_last  = m_id;
      act     = 1'b1;
      k       = e;
      m_we    = m_id ? we1 : we0;
      m_addr  = m_id ? addr1 : addr0;
      m_wdata = m_id ? wdata1 : wdata0;
    end
  endtask

  task automatic check_outputs();
    bit acc, rsp;
    logic [6:0] exp_ctl;
    acc = act && (e == k);
    rsp = act && (e == k + 1);
    exp_ctl = {acc && !m_id, acc && m_id, rsp && !m_id, rsp && m_id,
               acc && !m_we, acc && m_we, acc || rsp};
    check_eq("ctl", 64'({gnt0, gnt1, done0, done1, MemRead, MemWrite, busy}), 64'(exp_ctl));
    check_eq("addr", 64'(Address), 64'(m_addr));
    check_eq("wdata", 64'(WriteData), 64'(m_wdata));
    check_eq("rdata0", 64'(rdata0), 64'(m_rdata[0]));
    check_eq("rdata1", 64'(rdata1), 64'(m_rdata[1]));
  endtask

  // One clock: model follows the edge, outputs are compared at the following negedge.
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr    = a;
    pl_data    = d;
    pl_en      = 1'b1;
    ref_mem[a] = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    model_reset();
    #1;
    check_eq("rst_ctl", 64'({gnt0, gnt1, done0, done1, MemRead, MemWrite, busy}), 64'(0));
    check_eq("rst_rdata", 64'({rdata0, rdata1}), 64'(0));
    check_eq("rst_addr_wdata", 64'({Address, WriteData}), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int gq[$];
    int dq[$];
    int wr_snap;

    @(negedge clock);
    preload(8'd20, 32'h5555_5555);
    preload(8'd40, 32'hAAAA_AAAA);
    do_reset();

    // Lone read of a preloaded word.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd20;
    step();
    check_eq("r032_gnt0", 64'(gnt0), 64'(1));
    check_eq("r032_memread", 64'(MemRead), 64'(1));
    check_eq("r032_address", 64'(Address), 64'(20));
    req0 = 1'b0;
    step();
    check_eq("r032_done0", 64'(done0), 64'(1));
    check_eq("r032_rdata0", 64'(rdata0), 64'h5555_5555);
    step();

    // Write by requester 1, then read back by requester 0.
    wr_snap = wr_cnt;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd20; wdata1 = 32'hCCCC_CCCC;
    step();
    req1 = 1'b0;
    repeat (2) step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd20;
    step();
    req0 = 1'b0;
    repeat (2) step();
    check_eq("r033_writes", 64'(wr_cnt - wr_snap), 64'(1));
    check_eq("r033_rdata0", 64'(rdata0), 64'hCCCC_CCCC);
    check_eq("r033_rdata1", 64'(rdata1), 64'(0));

    // Both requesters held from reset: grants must alternate.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd40;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd40;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt0 || gnt1) gq.push_back(gnt1 ? 1 : 0);
      if (done0 || done1) dq.push_back(e);
    end
    req0 = 1'b0; req1 = 1'b0;
    check_eq("r034_ngrants", 64'(gq.size()), 64'(4));
    check_eq("r034_ndones", 64'(dq.size()), 64'(4));
    if (gq.size() == 4) begin
      check_eq("r034_order", 64'({gq[0][3:0], gq[1][3:0], gq[2][3:0], gq[3][3:0]}),
               64'h0101);
    end
    if (dq.size() == 4) begin
      check_eq("r034_gap1", 64'(dq[1] - dq[0]), 64'(3));
      check_eq("r034_gap2", 64'(dq[2] - dq[1]), 64'(3));
      check_eq("r034_gap3", 64'(dq[3] - dq[2]), 64'(3));
    end
    check_eq("r034_rdata0", 64'(rdata0), 64'hAAAA_AAAA);
    check_eq("r034_rdata1", 64'(rdata1), 64'hAAAA_AAAA);
    repeat (3) step();

    // Address change after the grant edge must not disturb the latched command.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd20;
    step();
    addr0 = 8'd40; req0 = 1'b0;
    #1;
    check_eq("r035_address_acc", 64'(Address), 64'(20));
    step();
    check_eq("r035_address_rsp", 64'(Address), 64'(20));
    step();

    // Reset during a write in ACCESS drops it without touching memory.
    wr_snap = wr_cnt;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd40; wdata0 = 32'h1234_5678;
    step();
    req0  = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("r036_memwrite", 64'(MemWrite), 64'(0));
    check_eq("r036_busy", 64'(busy), 64'(0));
    check_eq("r036_done", 64'({done0, done1}), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_eq("r036_mem40", 64'(mem[40]), 64'hAAAA_AAAA);
    check_eq("r036_writes", 64'(wr_cnt - wr_snap), 64'(0));
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd40;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd40;
    step();
    check_eq("r036_tie_gnt0", 64'({gnt0, gnt1}), 64'b10);
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) step();

    // Random traffic; inputs change every cycle, including during ACCESS/RESP.
    for (int i = 0; i < 400; i++) begin
      req0   = ($urandom_range(9, 0) < 6);
      req1   = ($urandom_range(9, 0) < 6);
      we0    = 1'($urandom_range(1, 0));
      we1    = 1'($urandom_range(1, 0));
      addr0  = 8'($urandom_range(47, 16));
      addr1  = 8'($urandom_range(47, 16));
      wdata0 = $urandom;
      wdata1 = $urandom;
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    for (int a = 16; a < 48; a++) begin
      check_eq("mem_final", 64'(mem[a]), 64'(ref_mem[a]));
    end
    check_eq("write_count", 64'(wr_cnt), 64'(m_wr_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: ADDR_W, 8, data-memory address width; DATA_W, 32, data-memory word width.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 reqN  input  1  requester N (N = 0, 1) access request; sampled only in IDLE.
REQ-005 weN  input  1  requester N access type: 1 = write, 0 = read.
REQ-006 addrN  input  ADDR_W  requester N word address.
REQ-007 wdataN  input  DATA_W  requester N write data.
REQ-008 gntN  output  1  one-cycle pulse: requester N's command was latched.
REQ-009 doneN  output  1  one-cycle pulse: requester N's access completed.
REQ-010 rdataN  output  DATA_W  requester N read result; holds until N's next completed read.
REQ-011 MemRead  output  1  read strobe to the data memory.
REQ-012 MemWrite  output  1  write strobe to the data memory; the memory writes on posedge clock.
REQ-013 Address  output  ADDR_W  memory address.
REQ-014 WriteData  output  DATA_W  memory write data.
REQ-015 ReadData  input  DATA_W  memory read data; combinational from Address when MemRead = 1.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-018 In IDLE with any reqN = 1 at a clock edge, the arbiter SHALL latch the winner's we/addr/wdata and id, set gntN = 1 for the next cycle, and enter ACCESS; with no request it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: a single request wins outright; on simultaneous requests the requester other than last_id wins, and last_id updates to the winner on every grant.
REQ-020 In ACCESS (exactly one cycle), Address/WriteData SHALL drive the latched values, MemWrite = latched we, MemRead = not latched we; the next state SHALL be RESP.
REQ-021 For a read, ReadData SHALL be captured into rdataN of the granted requester at the edge ending ACCESS; the other requester's rdata SHALL be unchanged.
REQ-022 In RESP, doneN of the granted requester SHALL be 1 for one cycle; the next state SHALL be IDLE.
REQ-023 Timing: req sampled at edge k, gnt high in cycle k+1, done high in cycle k+2, and the next request is sampled at edge k+3 (one access per 3 cycles).
REQ-024 Outside ACCESS, MemRead and MemWrite SHALL be 0; Address and WriteData SHALL hold the last latched values.
REQ-025 reqN asserted during ACCESS or RESP SHALL be ignored until IDLE; a requester still holding req in IDLE is treated as a new request.
REQ-026 The latched command SHALL be immune to changes on weN/addrN/wdataN after the grant edge.
REQ-027 gnt0/gnt1 and done0/done1 SHALL never be high in the same cycle.

Reset
REQ-028 While reset = 1: state = IDLE, last_id = 1 (requester 0 wins the first tie), and all outputs SHALL be 0, including rdata0/rdata1, Address, WriteData and busy.
REQ-029 Reset asserted in ACCESS SHALL force MemWrite to 0 immediately (before the clock edge), so no memory write occurs; the in-flight access is dropped without done.

Structure
REQ-030 Package dm_pkg SHALL hold the ADDR_W/DATA_W defaults and the FSM state enumeration (IDLE, ACCESS, RESP).
REQ-031 The two-way round-robin pick SHALL be a sub-module rr_arb2 (inputs req[1:0], last_id; output winner id); everything else is flat.

Verification
REQ-032 Behavioural memory preloaded with mem[20] = 0x55555555. req0 read addr 20 alone -> gnt0 at k+1, MemRead = 1 with Address = 20 in k+1, done0 at k+2, rdata0 = 0x55555555.
REQ-033 req1 write addr 20, data 0xCCCCCCCC, then req0 read addr 20 -> MemWrite pulses once; rdata0 = 0xCCCCCCCC; rdata1 unchanged (0).
REQ-034 req0 and req1 held high together from reset with memory preloaded mem[40] = 0xAAAAAAAA and both reading addr 40 -> grants alternate 0,1,0,1; each done is 3 cycles after the previous one; both rdata = 0xAAAAAAAA.
REQ-035 addr0 changed from 20 to 40 one cycle after gnt0 -> Address stays 20 throughout ACCESS.
REQ-036 Reset asserted mid-ACCESS of a write to addr 40 with data 0x12345678 -> MemWrite drops at once, mem[40] stays 0xAAAAAAAA, no done, busy = 0, next tie won by requester 0.
